// File: rtl/io_button.sv
// ---------------------------------------------------------------------------
// io_button
//
// Memory-mapped push-button input peripheral on the DMA IO bus.
// Each raw button pin is optionally inverted (so that 1 always means
// "pressed"), passed through a 2-flop synchronizer and debounced by its own
// counter. The CPU sees:
//   14'h3F81 BTN_LEVEL (RO)   debounced level, 1 = pressed
//   14'h3F82 BTN_EVENT (W1C)  sticky press flags, set on a 0->1 stable edge
//   14'h3F83 BTN_IRQEN (R/W)  per-button interrupt enable
// Any other read address passes dma_io_rdata_in through unchanged so that
// read data daisy-chains through every IO slave.
//
// Optional feature: define IO_BUTTON_IRQ_EN to implement BTN_IRQEN and the
// btn_irq output. Without it, BTN_IRQEN reads as zero, writes to it are
// dropped, and btn_irq is tied low.
//
// Parameters:
//   NBTN        number of buttons (1..16)
//   DEB_CNT     consecutive stable cycles needed to accept a new level (>=2)
//   ACTIVE_LOW  1 = a low pin means pressed
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   dma_io_we        IO write strobe
//   dma_io_wadr      IO write word address
//   dma_io_wdata     IO write data
//   dma_io_radr      IO read word address
//   dma_io_rdata_in  read data from the upstream slave
//   dma_io_rdata     read data to the downstream slave
//   btn_in           raw asynchronous button pins
//   btn_irq          level interrupt request
// ---------------------------------------------------------------------------
module io_button #(
    parameter int NBTN       = 3,
    parameter int DEB_CNT    = 250000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dma_io_we,
    input  logic [15:2]     dma_io_wadr,
    input  logic [15:0]     dma_io_wdata,
    input  logic [15:2]     dma_io_radr,
    input  logic [15:0]     dma_io_rdata_in,
    output logic [15:0]     dma_io_rdata,
    input  logic [NBTN-1:0] btn_in,
    output logic            btn_irq
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    localparam logic [15:2] ADR_LEVEL = 14'h3F81;
    localparam logic [15:2] ADR_EVENT = 14'h3F82;
    localparam logic [15:2] ADR_IRQEN = 14'h3F83;

    logic [NBTN-1:0] level_w;
    logic [NBTN-1:0] rise_w;
    logic [NBTN-1:0] event_q;
    logic [NBTN-1:0] event_d;
    logic [NBTN-1:0] clr_mask;
    logic [15:0]     irqen_rd;
    logic            unused_wdata;

    // Only the low NBTN write-data bits are meaningful.
    assign unused_wdata = ^dma_io_wdata;

    // -----------------------------------------------------------------------
    // Per-button synchronizer and debouncer
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
            logic          pin;
            logic          s1_q;
            logic          s1_d;
            logic          s2_q;
            logic          s2_d;
            logic          stable_q;
            logic          stable_d;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            assign pin = (ACTIVE_LOW != 0) ? ~btn_in[gi] : btn_in[gi];

            always_comb begin
                s1_d     = pin;
                s2_d     = s1_q;
                stable_d = stable_q;
                cnt_d    = '0;
                // Any sample agreeing with the accepted level restarts the
                // count, so only an uninterrupted run of DEB_CNT differing
                // samples moves the stable level.
                if (s2_q != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q     <= 1'b0;
                    s2_q     <= 1'b0;
                    stable_q <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    s1_q     <= s1_d;
                    s2_q     <= s2_d;
                    stable_q <= stable_d;
                    cnt_q    <= cnt_d;
                end
            end

            assign level_w[gi] = stable_q;
            // Press is the cycle in which the stable level is about to go 0->1.
            assign rise_w[gi]  = stable_d & ~stable_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Sticky press events, write-1-to-clear; a same-cycle press wins
    // -----------------------------------------------------------------------
    always_comb begin
        clr_mask = '0;
        if (dma_io_we && (dma_io_wadr == ADR_EVENT)) begin
            clr_mask = dma_io_wdata[NBTN-1:0];
        end
        event_d = (event_q & ~clr_mask) | rise_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_q <= '0;
        end else begin
            event_q <= event_d;
        end
    end

    // -----------------------------------------------------------------------
    // Optional interrupt enable register and request
    // -----------------------------------------------------------------------
`ifdef IO_BUTTON_IRQ_EN
    logic [NBTN-1:0] irqen_q;
    logic [NBTN-1:0] irqen_d;

    always_comb begin
        irqen_d = irqen_q;
        if (dma_io_we && (dma_io_wadr == ADR_IRQEN)) begin
            irqen_d = dma_io_wdata[NBTN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irqen_q <= '0;
        end else begin
            irqen_q <= irqen_d;
        end
    end

    assign irqen_rd = 16'(irqen_q);
    assign btn_irq  = |(event_q & irqen_q);
`else
    assign irqen_rd = 16'h0000;
    assign btn_irq  = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Combinational read mux with upstream pass-through
    // -----------------------------------------------------------------------
    always_comb begin
        dma_io_rdata = dma_io_rdata_in;
        case (dma_io_radr)
            ADR_LEVEL: dma_io_rdata = 16'(level_w);
            ADR_EVENT: dma_io_rdata = 16'(event_q);
            ADR_IRQEN: dma_io_rdata = irqen_rd;
            default:   dma_io_rdata = dma_io_rdata_in;
        endcase
    end

endmodule

// File: tb/tb_io_button.sv
module tb_io_button;

    localparam int NBTN = 3;
    localparam int DEB  = 4;

`ifdef IO_BUTTON_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    localparam logic [15:2] A_OTH = 14'h3F80;
    localparam logic [15:2] A_LVL = 14'h3F81;
    localparam logic [15:2] A_EVT = 14'h3F82;
    localparam logic [15:2] A_IEN = 14'h3F83;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            we       = 1'b0;
    logic [15:2]     wadr     = '0;
    logic [15:0]     wdata    = '0;
    logic [15:2]     radr     = '0;
    logic [15:0]     rdata_in = '0;
    logic [15:0]     rdata;
    logic [NBTN-1:0] btn_in   = '1;
    logic            irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: expectations queued when stimulus is applied.
    logic [15:0] exp_q[$];
    logic        irq_q[$];

    io_button #(.NBTN(NBTN), .DEB_CNT(DEB), .ACTIVE_LOW(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dma_io_we       (we),
        .dma_io_wadr     (wadr),
        .dma_io_wdata    (wdata),
        .dma_io_radr     (radr),
        .dma_io_rdata_in (rdata_in),
        .dma_io_rdata    (rdata),
        .btn_in          (btn_in),
        .btn_irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:2] a, input logic [15:0] d);
        we = 1'b1; wadr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [15:2] a, output logic [15:0] v);
        radr = a;
        #1;
        v = rdata;
    endtask

    task automatic test_reset();
        logic [15:2] a [4];
        logic [15:0] got, e;
        a[0] = A_LVL; a[1] = A_EVT; a[2] = A_IEN; a[3] = A_OTH;
        rst_n = 1'b0; btn_in = '1; rdata_in = 16'h1234;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h1234);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            rd(a[i], got);
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h expected %h", i, got, e);
            end
        end
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_press();
        logic [15:0] got, e;
        btn_in[0] = 1'b0;                       // edge 0 has just passed
        for (int k = 1; k <= 6; k++) exp_q.push_back((k < 6) ? 16'h0000 : 16'h0001);
        for (int k = 1; k <= 6; k++) begin
            tick();
            e = exp_q.pop_front();
            rd(A_LVL, got);
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL press_level edge%0d: got %h expected %h", k, got, e);
            end
            rd(A_EVT, got);
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL press_event edge%0d: got %h expected %h", k, got, e);
            end
        end
    endtask

    task automatic test_glitch();
        logic [15:0] got, e;
        btn_in[1] = 1'b0;
        repeat (3) tick();
        btn_in[1] = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(16'h0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            e = exp_q.pop_front();
            rd(A_LVL, got);
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL glitch_level cyc%0d: got %h expected %h", k, got, e);
            end
            rd(A_EVT, got);
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL glitch_event cyc%0d: got %h expected %h", k, got, e);
            end
        end
        // A full-length hold is accepted.
        btn_in[1] = 1'b0;
        for (int k = 1; k <= 6; k++) exp_q.push_back((k < 6) ? 16'h0001 : 16'h0003);
        for (int k = 1; k <= 6; k++) begin
            tick();
            e = exp_q.pop_front();
            rd(A_LVL, got);
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL hold_level edge%0d: got %h expected %h", k, got, e);
            end
        end
        rd(A_EVT, got);
        n_tests++;
        if (got !== 16'h0003) begin
            n_fail++;
            $display("FAIL hold_event: got %h expected 0003", got);
        end
    endtask

    task automatic test_w1c();
        logic [15:0] got, e;
        exp_q.push_back(16'h0002);              // after clearing bit 0
        exp_q.push_back(16'h0003);              // level unaffected by write
        exp_q.push_back(16'h0000);              // level after release
        exp_q.push_back(16'h0002);              // release sets nothing
        exp_q.push_back(16'h0000);              // after clearing bit 1
        exp_q.push_back(16'h0000);              // one cycle before new press
        exp_q.push_back(16'h0002);              // set wins over same-cycle clear
        wr(A_EVT, 16'h0001);
        rd(A_EVT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL w1c_bit0: got %h expected %h", got, e); end
        wr(A_LVL, 16'hFFFF);
        rd(A_LVL, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL level_ro: got %h expected %h", got, e); end
        btn_in = '1;
        repeat (8) tick();
        rd(A_LVL, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL release_level: got %h expected %h", got, e); end
        rd(A_EVT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL release_event: got %h expected %h", got, e); end
        wr(A_EVT, 16'h0002);
        rd(A_EVT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL w1c_bit1: got %h expected %h", got, e); end
        btn_in[1] = 1'b0;                       // edge 0
        repeat (5) tick();
        rd(A_EVT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL collide_pre: got %h expected %h", got, e); end
        we = 1'b1; wadr = A_EVT; wdata = 16'h0002;
        tick();                                 // edge 6: set and clear together
        we = 1'b0;
        rd(A_EVT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL collide_set_wins: got %h expected %h", got, e); end
    endtask

    task automatic test_irq();
        logic [15:0] got, e;
        logic        ei;
        wr(A_EVT, 16'h0007);
        exp_q.push_back(IRQ ? 16'h0004 : 16'h0000);
        wr(A_IEN, 16'h0004);
        rd(A_IEN, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL irqen_read: got %h expected %h", got, e); end
        btn_in[0] = 1'b0;                       // disabled button only
        for (int k = 0; k < 6; k++) irq_q.push_back(1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            ei = irq_q.pop_front(); n_tests++;
            if (irq !== ei) begin n_fail++; $display("FAIL irq_masked cyc%0d: got %b expected %b", k, irq, ei); end
        end
        btn_in[2] = 1'b0;                       // enabled button, edge 0
        for (int k = 1; k <= 6; k++) irq_q.push_back(IRQ && (k == 6));
        for (int k = 1; k <= 6; k++) begin
            tick();
            ei = irq_q.pop_front(); n_tests++;
            if (irq !== ei) begin n_fail++; $display("FAIL irq_rise edge%0d: got %b expected %b", k, irq, ei); end
        end
        exp_q.push_back(16'h0005);
        rd(A_EVT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL irq_event: got %h expected %h", got, e); end
        irq_q.push_back(IRQ);                   // still high during the write cycle
        irq_q.push_back(1'b0);                  // low after the write edge
        we = 1'b1; wadr = A_EVT; wdata = 16'h0004;
        #1;
        ei = irq_q.pop_front(); n_tests++;
        if (irq !== ei) begin n_fail++; $display("FAIL irq_clear_pre: got %b expected %b", irq, ei); end
        tick();
        we = 1'b0;
        ei = irq_q.pop_front(); n_tests++;
        if (irq !== ei) begin n_fail++; $display("FAIL irq_clear_post: got %b expected %b", irq, ei); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got, e;
        btn_in = '1;
        repeat (8) tick();
        wr(A_EVT, 16'h0007);
        btn_in[0] = 1'b0;
        repeat (4) tick();                      // counter is at 2
        rst_n = 1'b0;
        #1;
        exp_q.push_back(16'h0000);
        rd(A_EVT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL rst_mid_during: got %h expected %h", got, e); end
        tick();
        tick();
        rst_n = 1'b1;                           // release, pin still pressed
        for (int k = 1; k <= 6; k++) exp_q.push_back((k < 6) ? 16'h0000 : 16'h0001);
        for (int k = 1; k <= 6; k++) begin
            tick();
            rd(A_EVT, got); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL rst_mid_event edge%0d: got %h expected %h", k, got, e); end
        end
        exp_q.push_back(16'h0001);
        rd(A_LVL, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL rst_mid_level: got %h expected %h", got, e); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_w1c();
        test_irq();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
